// File: rtl/vc_out_tx.sv
// Transmit end of a credit-based virtual-channel link: per-VC credit tracking,
// round-robin selection among eligible VCs and a registered link flit.
module vc_out_tx #(
  parameter int N_VIRT_CHN = 2,
  parameter int FLIT_WIDTH = 34,
  parameter int BUFF_DEPTH = 4,
  localparam int VC_W = $clog2(N_VIRT_CHN),
  localparam int CR_W = $clog2(BUFF_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic [N_VIRT_CHN-1:0]          in_valid,
  output logic [N_VIRT_CHN-1:0]          in_ready,
  input  logic [N_VIRT_CHN*FLIT_WIDTH-1:0] in_flit,
  output logic                           out_valid,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic [VC_W-1:0]                out_vc_id,
  input  logic                           credit_valid,
  input  logic [VC_W-1:0]                credit_vc_id,
  output logic [N_VIRT_CHN*CR_W-1:0]     credits,
  output logic                           err_credit,
  output logic                           err_proto
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  localparam logic [1:0] T_HEAD      = 2'b00;
  localparam logic [1:0] T_BODY      = 2'b01;
  localparam logic [1:0] T_TAIL      = 2'b10;
  localparam logic [1:0] T_HEAD_TAIL = 2'b11;

  logic [CR_W-1:0]       cr [N_VIRT_CHN];
  logic [0:0]            st [N_VIRT_CHN];
  logic [VC_W-1:0]       ptr;
  logic [N_VIRT_CHN-1:0] elig;
  logic [N_VIRT_CHN-1:0] cr_ret;
  logic [N_VIRT_CHN-1:0] grant;
  logic                  gnt_any;
  logic [VC_W-1:0]       gnt_vc;
  logic [FLIT_WIDTH-1:0] gnt_flit;
  logic [1:0]            pkt_res;

  logic                  vld_p1;
  logic [FLIT_WIDTH-1:0] flit_p1;
  logic [VC_W-1:0]       vc_p1;
  logic                  err_credit_q;
  logic                  err_proto_q;

  // A simultaneous grant and return cancel; a return to a full counter is dropped.
  function automatic logic [CR_W-1:0] credit_next(input logic [CR_W-1:0] cur,
                                                  input logic dec, input logic inc);
    logic [CR_W-1:0] nxt;
    nxt = cur;
    if (dec && !inc)
      nxt = cur - 1'b1;
    else if (inc && !dec && cur != CR_W'(BUFF_DEPTH))
      nxt = cur + 1'b1;
    return nxt;
  endfunction

  // Returns {protocol_error, next_state}; an illegal type leaves the state alone.
  function automatic logic [1:0] pkt_step(input logic [0:0] cur, input logic [1:0] typ);
    logic [1:0] res;
    res = {1'b1, cur};
    if (cur == ST_IDLE) begin
      if (typ == T_HEAD)      res = {1'b0, ST_IN_PKT};
      if (typ == T_HEAD_TAIL) res = {1'b0, ST_IDLE};
    end else begin
      if (typ == T_BODY)      res = {1'b0, ST_IN_PKT};
      if (typ == T_TAIL)      res = {1'b0, ST_IDLE};
    end
    return res;
  endfunction

  genvar gv;
  generate
    for (gv = 0; gv < N_VIRT_CHN; gv++) begin : g_vc
      assign elig[gv]   = in_valid[gv] && (cr[gv] != '0);
      assign cr_ret[gv] = credit_valid && (credit_vc_id == VC_W'(gv));
      assign credits[gv*CR_W +: CR_W] = cr[gv];
    end
  endgenerate

  // Stage p0: round-robin search starting just after the last winner
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_vc  = '0;
    for (int i = 1; i <= N_VIRT_CHN; i++) begin
      idx = (int'(ptr) + i) % N_VIRT_CHN;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_vc  = VC_W'(idx);
      end
    end
  end

  assign grant    = gnt_any ? (N_VIRT_CHN'(1) << gnt_vc) : '0;
  assign in_ready = grant;
  assign gnt_flit = in_flit[int'(gnt_vc)*FLIT_WIDTH +: FLIT_WIDTH];
  assign pkt_res  = pkt_step(st[gnt_vc], gnt_flit[FLIT_WIDTH-1 -: 2]);

  // Stage p1: link register, credit counters and packet-state tracking
  always_ff @(posedge clk) begin
    if (arst) begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        cr[v] <= CR_W'(BUFF_DEPTH);
        st[v] <= ST_IDLE;
      end
      ptr          <= VC_W'(N_VIRT_CHN - 1);
      vld_p1       <= 1'b0;
      flit_p1      <= '0;
      vc_p1        <= '0;
      err_credit_q <= 1'b0;
      err_proto_q  <= 1'b0;
    end else begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        cr[v] <= credit_next(cr[v], grant[v], cr_ret[v]);
        if (cr_ret[v] && !grant[v] && cr[v] == CR_W'(BUFF_DEPTH))
          err_credit_q <= 1'b1;
      end
      vld_p1 <= gnt_any;
      if (gnt_any) begin
        ptr         <= gnt_vc;
        flit_p1     <= gnt_flit;
        vc_p1       <= gnt_vc;
        st[gnt_vc]  <= pkt_res[0];
        if (pkt_res[1])
          err_proto_q <= 1'b1;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_flit   = flit_p1;
  assign out_vc_id  = vc_p1;
  assign err_credit = err_credit_q;
  assign err_proto  = err_proto_q;

endmodule

// File: tb/tb_vc_out_tx.sv
// Bench for vc_out_tx: directed scenarios plus a random phase, with a
// reference model feeding a scoreboard that a negedge monitor drains.
module tb_vc_out_tx;
  localparam int N    = 2;
  localparam int FW   = 34;
  localparam int BD   = 4;
  localparam int VC_W = 1;
  localparam int CR_W = 3;

  localparam logic [1:0] HEAD = 2'b00;
  localparam logic [1:0] BODY = 2'b01;
  localparam logic [1:0] TAIL = 2'b10;
  localparam logic [1:0] HT   = 2'b11;

  logic                clk = 1'b0;
  logic                arst;
  logic [N-1:0]        in_valid;
  logic [N-1:0]        in_ready;
  logic [N*FW-1:0]     in_flit;
  logic                out_valid;
  logic [FW-1:0]       out_flit;
  logic [VC_W-1:0]     out_vc_id;
  logic                credit_valid;
  logic [VC_W-1:0]     credit_vc_id;
  logic [N*CR_W-1:0]   credits;
  logic                err_credit;
  logic                err_proto;

  vc_out_tx #(.N_VIRT_CHN(N), .FLIT_WIDTH(FW), .BUFF_DEPTH(BD)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_ready(in_ready),
    .in_flit(in_flit), .out_valid(out_valid), .out_flit(out_flit),
    .out_vc_id(out_vc_id), .credit_valid(credit_valid),
    .credit_vc_id(credit_vc_id), .credits(credits),
    .err_credit(err_credit), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              due;
    logic [FW-1:0]   flit;
    logic [VC_W-1:0] vc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: credit counts, packet-open flags, last winner, sticky errors
  int   m_cr [N];
  bit   m_pkt[N];
  int   m_ptr;
  bit   m_errc;
  bit   m_errp;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int p);
    return {t, 32'(p)};
  endfunction

  task automatic m_reset();
    for (int v = 0; v < N; v++) begin
      m_cr[v]  = BD;
      m_pkt[v] = 1'b0;
    end
    m_ptr  = N - 1;
    m_errc = 1'b0;
    m_errp = 1'b0;
  endtask

  // Monitor: reset cycles, scoreboard pops and hold-value checks
  int              rst_due   = 1;
  logic [FW-1:0]   hold_flit = '0;
  logic [VC_W-1:0] hold_vc   = '0;
  exp_t            mon_e;
  logic            due_now;

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (cyc == rst_due) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_out_flit", out_flit, 0);
        check("rst_out_vc", out_vc_id, 0);
        hold_flit = '0;
        hold_vc   = '0;
      end else if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("out_latency", cyc, mon_e.due);
          check("out_flit", out_flit, mon_e.flit);
          check("out_vc_id", out_vc_id, mon_e.vc);
          hold_flit = mon_e.flit;
          hold_vc   = mon_e.vc;
        end
      end else begin
        due_now = 1'b0;
        if (sb.size() > 0) due_now = (sb[0].due <= cyc);
        check("out_valid", out_valid, due_now);
        check("hold_flit", out_flit, hold_flit);
        check("hold_vc", out_vc_id, hold_vc);
      end
    end
  end

  // One cycle: check registered state, drive inputs, predict grant and next state
  task automatic step(input logic [N-1:0] iv, input logic [FW-1:0] f1, input logic [FW-1:0] f0,
                      input logic cv, input int cid, input logic r);
    logic [N*FW-1:0] fl;
    int              win;
    logic [N-1:0]    rdy;
    logic [1:0]      t;
    bit              starts, ends, g, c;
    exp_t            e;
    fl = {f1, f0};
    for (int v = 0; v < N; v++)
      check($sformatf("credits[%0d]", v), credits[v*CR_W +: CR_W], m_cr[v]);
    check("err_credit", err_credit, m_errc);
    check("err_proto", err_proto, m_errp);
    in_valid     = iv;
    in_flit      = fl;
    credit_valid = cv;
    credit_vc_id = VC_W'(cid);
    arst         = r;
    #1;
    if (r) begin
      m_reset();
      rst_due = cyc + 1;
    end else begin
      win = -1;
      for (int i = 1; i <= N; i++) begin
        int v;
        v = (m_ptr + i) % N;
        if (win < 0 && iv[v] && m_cr[v] > 0) win = v;
      end
      rdy = '0;
      if (win >= 0) rdy[win] = 1'b1;
      check("in_ready", in_ready, rdy);
      for (int v = 0; v < N; v++) begin
        g = (win == v);
        c = cv && (cid == v);
        if (g && !c) m_cr[v]--;
        else if (c && !g) begin
          if (m_cr[v] == BD) m_errc = 1'b1;
          else m_cr[v]++;
        end
      end
      if (win >= 0) begin
        m_ptr  = win;
        t      = fl[win*FW+FW-1 -: 2];
        starts = (t == HEAD) || (t == HT);
        ends   = (t == TAIL) || (t == HT);
        // A packet may only start when closed and only continue when open
        if (starts != m_pkt[win]) m_pkt[win] = !ends;
        else m_errp = 1'b1;
        e.due  = cyc + 1;
        e.flit = fl[win*FW +: FW];
        e.vc   = VC_W'(win);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic cv, input int cid);
    step('0, '0, '0, cv, cid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1; in_valid = '0; in_flit = '0; credit_valid = 1'b0; credit_vc_id = '0;
    m_reset();
    @(posedge clk);
    #1;
    step('0, '0, '0, 1'b0, 0, 1'b1);

    // One full packet on VC0 drains its credits, then a further flit stalls
    step(2'b01, '0, mk(HEAD, 1), 1'b0, 0, 1'b0);
    step(2'b01, '0, mk(BODY, 2), 1'b0, 0, 1'b0);
    step(2'b01, '0, mk(BODY, 3), 1'b0, 0, 1'b0);
    step(2'b01, '0, mk(TAIL, 4), 1'b0, 0, 1'b0);
    step(2'b01, '0, mk(HEAD, 5), 1'b0, 0, 1'b0);
    step(2'b01, '0, mk(HEAD, 5), 1'b0, 0, 1'b0);
    repeat (4) idle(1'b1, 0);

    // Both VCs continuously valid: alternating grants
    for (int i = 0; i < 6; i++)
      step(2'b11, mk(HT, 200 + i), mk(HT, 100 + i), 1'b0, 0, 1'b0);

    // VC1 at zero credits; a returned credit makes it eligible next cycle
    step(2'b10, mk(HT, 300), '0, 1'b0, 0, 1'b0);
    step(2'b10, mk(HT, 301), '0, 1'b1, 1, 1'b0);
    step(2'b10, mk(HT, 301), '0, 1'b0, 0, 1'b0);
    step(2'b10, mk(HT, 302), '0, 1'b0, 0, 1'b0);

    // Grant and return on VC0 together, then overflow a full counter
    idle(1'b1, 0);
    step(2'b01, '0, mk(HT, 400), 1'b1, 0, 1'b0);
    repeat (2) idle(1'b1, 0);
    repeat (4) idle(1'b1, 1);
    idle(1'b1, 0);
    idle(1'b0, 0);

    // Protocol errors: BODY on an idle VC, then HEAD twice
    step('0, '0, '0, 1'b0, 0, 1'b1);
    step(2'b01, '0, mk(BODY, 500), 1'b0, 0, 1'b0);
    step(2'b01, '0, mk(HEAD, 501), 1'b0, 0, 1'b0);
    step(2'b01, '0, mk(HEAD, 502), 1'b0, 0, 1'b0);

    // Reset mid-packet with VC0 at one credit, then BODY flags again
    step(2'b01, '0, mk(BODY, 600), 1'b0, 0, 1'b1);
    step(2'b01, '0, mk(BODY, 601), 1'b0, 0, 1'b0);
    idle(1'b0, 0);

    // Random traffic, credit returns and occasional resets
    for (int k = 0; k < 400; k++)
      step(N'($urandom_range(0, 3)),
           mk(2'($urandom_range(0, 3)), int'($urandom)),
           mk(2'($urandom_range(0, 3)), int'($urandom)),
           ($urandom_range(0, 1) == 0), int'($urandom_range(0, 1)),
           ($urandom_range(0, 79) == 0));

    repeat (3) idle(1'b0, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
